// File: rtl/cla_wide_add_sequencer.sv
// Multi-precision adder sequencer: streams WORDS x 16-bit operands through an external
// 16-bit CLA with ADD_LAT cycles of latency. Optional `SUBTRACT_EN adds the sub port.
module cla_wide_add_sequencer #(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                  Clk,
    input  logic                  Rs,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  cin,
`ifdef SUBTRACT_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(ADD_LAT + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state, nxt;
    logic [16*WORDS-1:0]   a_lat, b_lat;
    logic                  cin_lat, carry;
    logic [KW-1:0]         k;
    logic [CW-1:0]         wcnt;
    logic                  last, cap, accept;

    assign last   = (k == KW'(WORDS - 1));
    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign cap    = (state == S_ISSUE && ADD_LAT == 0) ||
                    (state == S_WAIT && wcnt == CW'(ADD_LAT));

    always_ff @(posedge Clk) begin
        if (Rs) state <= S_IDLE;
        else    state <= nxt;
    end

    always_comb begin
        nxt     = state;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_IDLE:  if (start) nxt = S_ISSUE;
            S_ISSUE: nxt = cap ? (last ? S_DONE : S_ISSUE) : S_WAIT;
            S_WAIT:  if (cap) nxt = last ? S_DONE : S_ISSUE;
            S_DONE:  nxt = start ? S_ISSUE : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (state == S_ISSUE || state == S_WAIT) begin
            busy    = 1'b1;
            add_a   = a_lat[{k, 4'b0000} +: 16];
            add_b   = b_lat[{k, 4'b0000} +: 16];
            add_cin = (k == '0) ? cin_lat : carry;
        end
        if (state == S_DONE) done = 1'b1;
    end

    // Subtraction folds into the latched operands: B is stored inverted and word-0 carry forced high.
    always_ff @(posedge Clk) begin
        if (Rs) begin
            a_lat   <= '0;
            b_lat   <= '0;
            cin_lat <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
            wcnt    <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            if (accept) begin
                a_lat <= op_a;
                k     <= '0;
`ifdef SUBTRACT_EN
                b_lat   <= sub ? ~op_b : op_b;
                cin_lat <= sub ? 1'b1 : cin;
`else
                b_lat   <= op_b;
                cin_lat <= cin;
`endif
            end
            if (state == S_ISSUE)     wcnt <= CW'(1);
            else if (state == S_WAIT) wcnt <= wcnt + CW'(1);
            if (cap) begin
                result[{k, 4'b0000} +: 16] <= add_sum;
                carry <= add_cout;
                if (last) cout <= add_cout;
                else      k    <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cla_wide_add_sequencer.sv
// Self-checking bench for cla_wide_add_sequencer: registered CLA responder, wide-arithmetic
// reference model with per-cycle comparison, and directed vectors with literal expectations.
module tb_cla_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int LAT   = 1;
    localparam int W     = 16 * WORDS;
    localparam int N     = WORDS * (LAT + 1);

    logic           Clk = 1'b0;
    logic           Rs, start, cin;
    logic [W-1:0]   op_a, op_b;
    logic           busy, done, cout, add_cin, add_cout;
    logic [W-1:0]   result;
    logic [15:0]    add_a, add_b, add_sum;
`ifdef SUBTRACT_EN
    logic           sub;
`endif

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always #5 Clk = ~Clk;

    cla_wide_add_sequencer #(.WORDS(WORDS), .ADD_LAT(LAT)) dut (
        .Clk(Clk), .Rs(Rs), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .result(result), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Registered 16-bit CLA stand-in (one cycle of latency)
    always @(posedge Clk)
        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: cyc 0 idle, 1..N busy, N+1 done pulse
    int           cyc = 0;
    logic [W-1:0] ma = '0, mb = '0, mres = '0;
    logic         mcin = 1'b0, mcout = 1'b0;

    always @(posedge Clk) begin
        if (Rs) begin
            cyc   <= 0;
            mres  <= '0;
            mcout <= 1'b0;
        end else if (start && (cyc == 0 || cyc == N + 1)) begin
            cyc <= 1;
            ma  <= op_a;
`ifdef SUBTRACT_EN
            mb   <= sub ? ~op_b : op_b;
            mcin <= sub ? 1'b1 : cin;
`else
            mb   <= op_b;
            mcin <= cin;
`endif
        end else if (cyc == N + 1) begin
            cyc <= 0;
        end else if (cyc != 0) begin
            cyc <= cyc + 1;
            if (cyc == N) {mcout, mres} <= {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
        end
    end

    function automatic logic cin_into(input int p);
        logic [W:0] m, s;
        if (p == 0) return mcin;
        m = ((W+1)'(1) << (16 * p)) - (W+1)'(1);
        s = ({1'b0, ma} & m) + ({1'b0, mb} & m) + (W+1)'(mcin);
        return s[16 * p];
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            logic eb;
            int   p;
            eb = (cyc >= 1 && cyc <= N);
            chk("mon_busy", (W+1)'(busy), (W+1)'(eb));
            chk("mon_done", (W+1)'(done), (W+1)'(cyc == N + 1));
            if (!eb) begin
                chk("mon_result", (W+1)'(result), (W+1)'(mres));
                chk("mon_cout", (W+1)'(cout), (W+1)'(mcout));
                chk("mon_add_idle", (W+1)'({add_a, add_b, add_cin}), '0);
            end else begin
                p = (cyc - 1) / (LAT + 1);
                chk("mon_add_a", (W+1)'(add_a), (W+1)'(ma[16*p +: 16]));
                chk("mon_add_b", (W+1)'(add_b), (W+1)'(mb[16*p +: 16]));
                chk("mon_add_cin", (W+1)'(add_cin), (W+1)'(cin_into(p)));
            end
        end
    end

    // Issue one request; n = cycle after accept in which done is seen, cs = add_cin per pass
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int n, output logic [3:0] cs);
        @(negedge Clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        cs = '0;
        n  = 0;
        while (!(n > 0 && done) && n < 40) begin
            @(negedge Clk);
            n++;
            start = 1'b0;
            if (n % 2 == 1 && n <= 7) cs[(n - 1) / 2] = add_cin;
        end
        if (n >= 40) chk("timeout_done", 1, 0);
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            @(negedge Clk);
            n++;
            start = 1'b0;
        end
        if (n >= 40) chk("timeout_done", 1, 0);
    endtask

    initial begin
        int n, dn;
        logic [3:0] cs;
        Rs = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
`ifdef SUBTRACT_EN
        sub = 1'b0;
`endif
        // Test 1: reset state
        repeat (2) @(negedge Clk);
        chk("t1_reset_outs", (W+1)'({busy, done, cout, add_a, add_b, add_cin}), '0);
        chk("t1_reset_result", (W+1)'(result), '0);
        mon_en = 1'b1;
        Rs = 1'b0;

        // Test 2: full carry ripple, latency and pulse width
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, n, cs);
        chk("t2_latency", (W+1)'(n), (W+1)'(9));
        chk("t2_result", (W+1)'(result), '0);
        chk("t2_cout", (W+1)'(cout), (W+1)'(1));
        chk("t2_carry_seq", (W+1)'(cs), (W+1)'(4'b1110));
        @(negedge Clk);
        chk("t2_done_width", (W+1)'(done), '0);

        // Test 3: cin used only on word 0
        run(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, n, cs);
        chk("t3_result", (W+1)'(result), (W+1)'(64'h0011_0022_0033_0045));
        chk("t3_cout", (W+1)'(cout), '0);
        chk("t3_carry_seq", (W+1)'(cs), (W+1)'(4'b0001));

        // Alternating word carries
        run(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, n, cs);
        chk("alt_result", (W+1)'(result), (W+1)'(64'h0001_0000_0001_0000));
        chk("alt_carry_seq", (W+1)'(cs), (W+1)'(4'b1010));

        // Test 4: start while busy ignored; back-to-back accept from DONE
        @(negedge Clk);
        op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; cin = 1'b0; start = 1'b1;
        @(negedge Clk); start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        op_a = 64'h1234_1234_1234_1234; op_b = 64'h1111_1111_1111_1111; cin = 1'b1; start = 1'b1;
        @(negedge Clk); start = 1'b0;
        wait_done(4, n);
        chk("t4_ignore_latency", (W+1)'(n), (W+1)'(9));
        chk("t4_ignore_result", (W+1)'(result), '0);
        chk("t4_ignore_cout", (W+1)'(cout), (W+1)'(1));
        op_a = 64'h8000_0000_0000_0000; op_b = 64'h8000_0000_0000_0001; cin = 1'b0; start = 1'b1;
        @(negedge Clk); start = 1'b0;
        chk("t4_b2b_busy", (W+1)'(busy), (W+1)'(1));
        wait_done(1, n);
        chk("t4_b2b_latency", (W+1)'(n), (W+1)'(9));
        chk("t4_b2b_result", (W+1)'(result), (W+1)'(64'h1));
        chk("t4_b2b_cout", (W+1)'(cout), (W+1)'(1));

        // Test 5: reset mid-operation aborts without done
        @(negedge Clk);
        op_a = 64'h1111_1111_1111_1111; op_b = 64'h2222_2222_2222_2222; cin = 1'b0; start = 1'b1;
        @(negedge Clk); start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rs = 1'b1;
        @(negedge Clk);
        Rs = 1'b0;
        chk("t5_abort_busy", (W+1)'(busy), '0);
        chk("t5_abort_result", (W+1)'(result), '0);
        dn = 0;
        repeat (12) begin
            @(negedge Clk);
            if (done) dn++;
        end
        chk("t5_no_done", (W+1)'(dn), '0);
        run(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, n, cs);
        chk("t5_after_result", (W+1)'(result), (W+1)'(64'h1234_5678_9ABC_DF00));
        chk("t5_after_cout", (W+1)'(cout), '0);

`ifdef SUBTRACT_EN
        // Test 6: subtraction
        sub = 1'b1;
        run(64'd5, 64'd7, 1'b0, n, cs);
        chk("t6_sub_neg", (W+1)'(result), (W+1)'(64'hFFFF_FFFF_FFFF_FFFE));
        chk("t6_sub_neg_cout", (W+1)'(cout), '0);
        run(64'd7, 64'd5, 1'b0, n, cs);
        chk("t6_sub_pos", (W+1)'(result), (W+1)'(64'h2));
        chk("t6_sub_pos_cout", (W+1)'(cout), (W+1)'(1));
        sub = 1'b0;
`endif

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
